// File: rtl/riscv_mem_pkg.sv
// Shared encodings and bundles for the data-memory stage.
// Imported by memory_stage and store_unit.
package riscv_mem_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic {
      IDLE,
      WAIT
   } mem_state_t;

   typedef struct packed {
      logic [31:0] result;
      logic [2:0]  funct3;
      logic [4:0]  rd;
      logic        write_reg;
      logic        select;
   } mem_ctrl_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        we;
      mem_ctrl_t   ctrl;
   } mem_req_t;

   typedef struct packed {
      mem_ctrl_t   ctrl;
      logic [31:0] out;
   } mem_wb_t;

endpackage

// File: rtl/store_unit.sv
// Lane steering for data-memory accesses: byte enables,
// replicated store data and alignment check.
module store_unit
   import riscv_mem_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  offset_i,
   input  logic [31:0] data_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic        misaligned_o
);

   always_comb begin
      be_o         = 4'b1111;
      wdata_o      = data_i;
      misaligned_o = (offset_i != 2'b00);
      unique case (funct3_i)
         F3_LB, F3_LBU: begin
            be_o         = 4'b0001 << offset_i;
            wdata_o      = {4{data_i[7:0]}};
            misaligned_o = 1'b0;
         end
         F3_LH, F3_LHU: begin
            be_o         = 4'b0011 << offset_i;
            wdata_o      = {2{data_i[15:0]}};
            misaligned_o = offset_i[0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/memory_stage.sv
// EX/MEM -> MEM/WB stage: issues data-memory transfers over a
// valid/ready handshake and stalls the front end while one is pending.
module memory_stage
   import riscv_mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_from_execute,
   input  logic [31:0] result_from_execute,
   input  logic [31:0] store_data_from_execute,
   input  logic [2:0]  funct3_from_execute,
   input  logic [4:0]  rd_from_execute,
   input  logic        write_reg_from_execute,
   input  logic        select_from_execute,
   input  logic        mem_read_from_execute,
   input  logic        mem_write_from_execute,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,
   output logic        stall_from_memory,
   output logic        misaligned_from_memory,
   output logic        bus_error_from_memory,
   output logic [31:0] result_from_memory,
   output logic [2:0]  funct3_from_memory,
   output logic [4:0]  rd_from_memory,
   output logic [31:0] out_from_memory,
   output logic        write_reg_from_memory,
   output logic        select_from_memory
);

   mem_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   mem_req_t         hold_q, hold_d, ex_req;
   mem_wb_t          mw_q, mw_d;
   logic             mis_q, mis_d;
   logic             berr_q, berr_d;
   logic             access;
   logic             su_mis;
   logic             req_c;
   logic             stall_c;
   logic [3:0]       su_be;
   logic [31:0]      su_wdata;

   store_unit u_store (
      .funct3_i     (funct3_from_execute),
      .offset_i     (result_from_execute[1:0]),
      .data_i       (store_data_from_execute),
      .be_o         (su_be),
      .wdata_o      (su_wdata),
      .misaligned_o (su_mis)
   );

   assign access = valid_from_execute
                 & (mem_read_from_execute | mem_write_from_execute);

   // Read+write together is resolved as a store; stores never write rd.
   always_comb begin
      ex_req.addr           = {result_from_execute[31:2], 2'b00};
      ex_req.wdata          = su_wdata;
      ex_req.be             = su_be;
      ex_req.we             = mem_write_from_execute;
      ex_req.ctrl.result    = result_from_execute;
      ex_req.ctrl.funct3    = funct3_from_execute;
      ex_req.ctrl.rd        = rd_from_execute;
      ex_req.ctrl.write_reg = write_reg_from_execute
                            & ~mem_write_from_execute;
      ex_req.ctrl.select    = select_from_execute;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      mw_d    = '0;
      mis_d   = 1'b0;
      berr_d  = 1'b0;
      req_c   = 1'b0;
      stall_c = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (access && su_mis) begin
               mis_d                = 1'b1;
               mw_d.ctrl            = ex_req.ctrl;
               mw_d.ctrl.write_reg  = 1'b0;
            end else if (access) begin
               req_c  = 1'b1;
               hold_d = ex_req;
               if (dmem_ready) begin
                  mw_d.ctrl = ex_req.ctrl;
                  mw_d.out  = ex_req.we ? 32'h0 : dmem_rdata;
               end else begin
                  state_d = WAIT;
                  cnt_d   = '0;
                  stall_c = 1'b1;
               end
            end else if (valid_from_execute) begin
               mw_d.ctrl = ex_req.ctrl;
            end
         end
         WAIT: begin
            req_c = 1'b1;
            if (dmem_ready) begin
               mw_d.ctrl = hold_q.ctrl;
               mw_d.out  = hold_q.we ? 32'h0 : dmem_rdata;
               state_d   = IDLE;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               berr_d  = 1'b1;
               state_d = IDLE;
               cnt_d   = '0;
               stall_c = 1'b1;
            end else begin
               cnt_d   = cnt_q + 1'b1;
               stall_c = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hold_q  <= '0;
         mw_q    <= '0;
         mis_q   <= 1'b0;
         berr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         mw_q    <= mw_d;
         mis_q   <= mis_d;
         berr_q  <= berr_d;
      end
   end

   assign dmem_req   = req_c & ~rst;
   assign dmem_we    = (state_q == WAIT) ? hold_q.we    : ex_req.we;
   assign dmem_addr  = (state_q == WAIT) ? hold_q.addr  : ex_req.addr;
   assign dmem_wdata = (state_q == WAIT) ? hold_q.wdata : ex_req.wdata;
   assign dmem_be    = (state_q == WAIT) ? hold_q.be    : ex_req.be;

   assign stall_from_memory      = stall_c & ~rst;
   assign misaligned_from_memory = mis_q;
   assign bus_error_from_memory  = berr_q;
   assign result_from_memory     = mw_q.ctrl.result;
   assign funct3_from_memory     = mw_q.ctrl.funct3;
   assign rd_from_memory         = mw_q.ctrl.rd;
   assign write_reg_from_memory  = mw_q.ctrl.write_reg;
   assign select_from_memory     = mw_q.ctrl.select;
   assign out_from_memory        = mw_q.out;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios plus
// randomized transfers against a transaction-level reference model.
module tb_memory_stage;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_from_execute;
   logic [31:0] result_from_execute;
   logic [31:0] store_data_from_execute;
   logic [2:0]  funct3_from_execute;
   logic [4:0]  rd_from_execute;
   logic        write_reg_from_execute;
   logic        select_from_execute;
   logic        mem_read_from_execute;
   logic        mem_write_from_execute;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;
   logic        stall_from_memory;
   logic        misaligned_from_memory;
   logic        bus_error_from_memory;
   logic [31:0] result_from_memory;
   logic [2:0]  funct3_from_memory;
   logic [4:0]  rd_from_memory;
   logic [31:0] out_from_memory;
   logic        write_reg_from_memory;
   logic        select_from_memory;

   int vecs = 0;
   int errs = 0;

   memory_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
      .clk                     (clk),
      .rst                     (rst),
      .valid_from_execute      (valid_from_execute),
      .result_from_execute     (result_from_execute),
      .store_data_from_execute (store_data_from_execute),
      .funct3_from_execute     (funct3_from_execute),
      .rd_from_execute         (rd_from_execute),
      .write_reg_from_execute  (write_reg_from_execute),
      .select_from_execute     (select_from_execute),
      .mem_read_from_execute   (mem_read_from_execute),
      .mem_write_from_execute  (mem_write_from_execute),
      .dmem_req                (dmem_req),
      .dmem_we                 (dmem_we),
      .dmem_addr               (dmem_addr),
      .dmem_wdata              (dmem_wdata),
      .dmem_be                 (dmem_be),
      .dmem_ready              (dmem_ready),
      .dmem_rdata              (dmem_rdata),
      .stall_from_memory       (stall_from_memory),
      .misaligned_from_memory  (misaligned_from_memory),
      .bus_error_from_memory   (bus_error_from_memory),
      .result_from_memory      (result_from_memory),
      .funct3_from_memory      (funct3_from_memory),
      .rd_from_memory          (rd_from_memory),
      .out_from_memory         (out_from_memory),
      .write_reg_from_memory   (write_reg_from_memory),
      .select_from_memory      (select_from_memory)
   );

   always #5 clk = ~clk;

   // Reference model: access size in bytes from funct3.
   function automatic int acc_size(input logic [2:0] f3);
      if (f3[1:0] == 2'd0) return 1;
      if (f3[1:0] == 2'd1) return 2;
      return 4;
   endfunction

   function automatic logic m_mis(input logic [2:0] f3,
                                  input logic [31:0] a);
      return (a % 32'(acc_size(f3))) != 0;
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] f3,
                                       input logic [31:0] a);
      logic [3:0] m;
      m = 4'((32'd1 << acc_size(f3)) - 32'd1);
      return m << a[1:0];
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3,
                                           input logic [31:0] d);
      if (acc_size(f3) == 1) return 32'(d[7:0]) * 32'h0101_0101;
      if (acc_size(f3) == 2) return 32'(d[15:0]) * 32'h0001_0001;
      return d;
   endfunction

   task automatic drive(input logic v, input logic [31:0] res,
                        input logic [31:0] sd, input logic [2:0] f3,
                        input logic [4:0] rd, input logic wr,
                        input logic sel, input logic mr,
                        input logic mw);
      valid_from_execute      = v;
      result_from_execute     = res;
      store_data_from_execute = sd;
      funct3_from_execute     = f3;
      rd_from_execute         = rd;
      write_reg_from_execute  = wr;
      select_from_execute     = sel;
      mem_read_from_execute   = mr;
      mem_write_from_execute  = mw;
   endtask

   task automatic idle_in;
      drive(1'b0, 32'h0, 32'h0, 3'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset;
      rst        = 1'b1;
      dmem_ready = 1'b1;
      dmem_rdata = 32'h1111_2222;
      drive(1'b1, 32'h200, 32'h0, 3'b010, 5'd1, 1'b1, 1'b1,
            1'b1, 1'b0);
      @(negedge clk);
      #1;
      vecs++;
      if (dmem_req !== 1'b0 || stall_from_memory !== 1'b0)
         $display("FAIL reset_gate: req=%b stall=%b want 0 0",
                  dmem_req, stall_from_memory);
      if (dmem_req !== 1'b0 || stall_from_memory !== 1'b0) errs++;
      @(negedge clk);
      idle_in();
      dmem_ready = 1'b0;
      vecs++;
      if ({misaligned_from_memory, bus_error_from_memory,
           result_from_memory, funct3_from_memory, rd_from_memory,
           out_from_memory, write_reg_from_memory,
           select_from_memory} !== '0) begin
         errs++;
         $display("FAIL reset_regs: res=%h out=%h wr=%b want 0",
                  result_from_memory, out_from_memory,
                  write_reg_from_memory);
      end
      rst = 1'b0;
   endtask

   task automatic test_alu;
      @(negedge clk);
      drive(1'b1, 32'h0000_1234, 32'h0, 3'b000, 5'd5, 1'b1, 1'b0,
            1'b0, 1'b0);
      #1;
      vecs++;
      if (dmem_req !== 1'b0 || stall_from_memory !== 1'b0) begin
         errs++;
         $display("FAIL alu_req: req=%b stall=%b want 0 0",
                  dmem_req, stall_from_memory);
      end
      @(negedge clk);
      idle_in();
      vecs++;
      if ({result_from_memory, rd_from_memory, write_reg_from_memory,
           out_from_memory} !== {32'h1234, 5'd5, 1'b1, 32'h0}) begin
         errs++;
         $display("FAIL alu_wb: res=%h rd=%0d wr=%b out=%h",
                  result_from_memory, rd_from_memory,
                  write_reg_from_memory, out_from_memory);
      end
   endtask

   task automatic test_store_same_cycle;
      @(negedge clk);
      drive(1'b1, 32'h103, 32'h0000_00AB, 3'b000, 5'd4, 1'b1, 1'b0,
            1'b0, 1'b1);
      dmem_ready = 1'b1;
      #1;
      vecs++;
      if ({dmem_req, dmem_we, dmem_be, dmem_wdata, dmem_addr,
           stall_from_memory} !==
          {1'b1, 1'b1, 4'b1000, 32'hABAB_ABAB, 32'h100, 1'b0}) begin
         errs++;
         $display("FAIL sb_bus: req=%b we=%b be=%b wd=%h a=%h st=%b",
                  dmem_req, dmem_we, dmem_be, dmem_wdata, dmem_addr,
                  stall_from_memory);
      end
      @(negedge clk);
      idle_in();
      dmem_ready = 1'b0;
      vecs++;
      if (write_reg_from_memory !== 1'b0 || out_from_memory !== 0) begin
         errs++;
         $display("FAIL sb_wb: wr=%b out=%h want 0 0",
                  write_reg_from_memory, out_from_memory);
      end
   endtask

   task automatic test_load_wait;
      @(negedge clk);
      drive(1'b1, 32'h200, 32'h0, 3'b010, 5'd7, 1'b1, 1'b1,
            1'b1, 1'b0);
      dmem_ready = 1'b0;
      #1;
      vecs++;
      if (dmem_req !== 1'b1 || stall_from_memory !== 1'b1) begin
         errs++;
         $display("FAIL lw_issue: req=%b stall=%b want 1 1",
                  dmem_req, stall_from_memory);
      end
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         drive(1'b1, $urandom, $urandom, 3'b000, 5'd9, 1'b1, 1'b0,
               1'b0, 1'b1);
         dmem_ready = (k == 3);
         dmem_rdata = (k == 3) ? 32'hDEAD_BEEF : $urandom;
         vecs++;
         if (write_reg_from_memory !== 1'b0 ||
             result_from_memory !== 0 || out_from_memory !== 0) begin
            errs++;
            $display("FAIL lw_bubble%0d: wr=%b res=%h out=%h", k,
                     write_reg_from_memory, result_from_memory,
                     out_from_memory);
         end
         #1;
         vecs++;
         if ({dmem_req, dmem_we, dmem_addr, dmem_be} !==
             {1'b1, 1'b0, 32'h200, 4'hF}) begin
            errs++;
            $display("FAIL lw_hold%0d: req=%b we=%b a=%h be=%b", k,
                     dmem_req, dmem_we, dmem_addr, dmem_be);
         end
         vecs++;
         if (stall_from_memory !== (k < 3)) begin
            errs++;
            $display("FAIL lw_stall%0d: got %b want %b", k,
                     stall_from_memory, k < 3);
         end
      end
      @(negedge clk);
      idle_in();
      dmem_ready = 1'b0;
      vecs++;
      if ({out_from_memory, select_from_memory, write_reg_from_memory,
           rd_from_memory, result_from_memory, funct3_from_memory} !==
          {32'hDEAD_BEEF, 1'b1, 1'b1, 5'd7, 32'h200, 3'b010}) begin
         errs++;
         $display("FAIL lw_wb: out=%h sel=%b wr=%b rd=%0d res=%h",
                  out_from_memory, select_from_memory,
                  write_reg_from_memory, rd_from_memory,
                  result_from_memory);
      end
   endtask

   task automatic test_misaligned;
      @(negedge clk);
      drive(1'b1, 32'h201, 32'h0, 3'b001, 5'd6, 1'b1, 1'b1,
            1'b1, 1'b0);
      #1;
      vecs++;
      if (dmem_req !== 1'b0 || stall_from_memory !== 1'b0) begin
         errs++;
         $display("FAIL mis_req: req=%b stall=%b want 0 0",
                  dmem_req, stall_from_memory);
      end
      @(negedge clk);
      idle_in();
      vecs++;
      if (misaligned_from_memory !== 1'b1 ||
          write_reg_from_memory !== 1'b0) begin
         errs++;
         $display("FAIL mis_pulse: mis=%b wr=%b want 1 0",
                  misaligned_from_memory, write_reg_from_memory);
      end
      @(negedge clk);
      vecs++;
      if (misaligned_from_memory !== 1'b0) begin
         errs++;
         $display("FAIL mis_len: mis=%b want 0",
                  misaligned_from_memory);
      end
   endtask

   task automatic test_timeout;
      int st;
      st = 0;
      @(negedge clk);
      drive(1'b1, 32'h300, 32'h0, 3'b010, 5'd3, 1'b1, 1'b1,
            1'b1, 1'b0);
      dmem_ready = 1'b0;
      for (int k = 1; k <= TO; k++) begin
         @(negedge clk);
         dmem_rdata = $urandom;
         #1;
         if (stall_from_memory === 1'b1 && dmem_req === 1'b1) st++;
      end
      vecs++;
      if (st != TO) begin
         errs++;
         $display("FAIL to_wait: stalled %0d want %0d", st, TO);
      end
      @(negedge clk);
      idle_in();
      vecs++;
      if (bus_error_from_memory !== 1'b1 ||
          write_reg_from_memory !== 1'b0) begin
         errs++;
         $display("FAIL to_pulse: berr=%b wr=%b want 1 0",
                  bus_error_from_memory, write_reg_from_memory);
      end
      #1;
      vecs++;
      if (stall_from_memory !== 1'b0) begin
         errs++;
         $display("FAIL to_stall: got %b want 0", stall_from_memory);
      end
      @(negedge clk);
      vecs++;
      if (bus_error_from_memory !== 1'b0) begin
         errs++;
         $display("FAIL to_len: berr=%b want 0",
                  bus_error_from_memory);
      end
   endtask

   task automatic test_reset_in_wait;
      @(negedge clk);
      drive(1'b1, 32'h400, 32'h0, 3'b010, 5'd8, 1'b1, 1'b1,
            1'b1, 1'b0);
      dmem_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      vecs++;
      if (dmem_req !== 1'b0 || stall_from_memory !== 1'b0) begin
         errs++;
         $display("FAIL rstw_gate: req=%b stall=%b want 0 0",
                  dmem_req, stall_from_memory);
      end
      @(negedge clk);
      rst = 1'b0;
      idle_in();
      dmem_ready = 1'b1;
      dmem_rdata = 32'hCAFE_F00D;
      #1;
      vecs++;
      if (dmem_req !== 1'b0 || stall_from_memory !== 1'b0) begin
         errs++;
         $display("FAIL rstw_idle: req=%b stall=%b want 0 0",
                  dmem_req, stall_from_memory);
      end
      @(negedge clk);
      dmem_ready = 1'b0;
      vecs++;
      if ({result_from_memory, out_from_memory, rd_from_memory,
           write_reg_from_memory, select_from_memory} !== '0) begin
         errs++;
         $display("FAIL rstw_wb: res=%h out=%h wr=%b want 0",
                  result_from_memory, out_from_memory,
                  write_reg_from_memory);
      end
   endtask

   task automatic test_random;
      for (int n = 0; n < 60; n++) begin
         logic        v, mr, mw, wr, sel, acc, mis, done;
         logic [31:0] a, sd, rdat, ea;
         logic [2:0]  f3;
         logic [4:0]  rd;
         int          kind, lat, r;
         kind = $urandom_range(0, 9);
         v    = (kind != 0);
         mr   = (kind >= 2 && kind <= 5) || kind == 9;
         mw   = (kind >= 6);
         wr   = 1'($urandom);
         sel  = 1'($urandom);
         rd   = 5'($urandom);
         sd   = $urandom;
         a    = $urandom;
         if (mw) begin
            f3 = 3'($urandom_range(0, 2));
         end else if (mr) begin
            r  = $urandom_range(0, 4);
            f3 = (r < 3) ? 3'(r) : 3'(r + 1);
         end else begin
            f3 = 3'($urandom);
         end
         if ($urandom_range(0, 3) != 0)
            a = a & ~32'(acc_size(f3) - 1);
         lat = ($urandom_range(0, 7) == 0) ? 30 : $urandom_range(0, 4);
         acc = v & (mr | mw);
         mis = acc && m_mis(f3, a);
         ea  = {a[31:2], 2'b00};
         @(negedge clk);
         drive(v, a, sd, f3, rd, wr, sel, mr, mw);
         if (!acc || mis) begin
            dmem_ready = 1'($urandom);
            dmem_rdata = $urandom;
            #1;
            vecs++;
            if (dmem_req !== 1'b0 || stall_from_memory !== 1'b0) begin
               errs++;
               $display("FAIL rnd%0d_noreq: req=%b stall=%b", n,
                        dmem_req, stall_from_memory);
            end
            @(negedge clk);
            idle_in();
            dmem_ready = 1'b0;
            vecs++;
            if (mis) begin
               if ({misaligned_from_memory, write_reg_from_memory,
                    out_from_memory, bus_error_from_memory} !==
                   {1'b1, 1'b0, 32'h0, 1'b0}) begin
                  errs++;
                  $display("FAIL rnd%0d_mis: mis=%b wr=%b out=%h", n,
                           misaligned_from_memory,
                           write_reg_from_memory, out_from_memory);
               end
            end else if ({result_from_memory, funct3_from_memory,
                          rd_from_memory, out_from_memory,
                          write_reg_from_memory, select_from_memory,
                          misaligned_from_memory,
                          bus_error_from_memory} !==
                         (v ? {a, f3, rd, 32'h0, wr, sel, 2'b00}
                            : 76'h0)) begin
               errs++;
               $display("FAIL rnd%0d_pass: res=%h rd=%0d wr=%b out=%h",
                        n, result_from_memory, rd_from_memory,
                        write_reg_from_memory, out_from_memory);
            end
         end else begin
            done = 1'b0;
            rdat = 32'h0;
            for (int c = 0; c <= TO && !done; c++) begin
               if (c > 0) begin
                  @(negedge clk);
                  drive(1'b1, $urandom, $urandom, 3'($urandom),
                        5'($urandom), 1'b1, 1'b1, 1'($urandom),
                        1'($urandom));
                  vecs++;
                  if ({result_from_memory, funct3_from_memory,
                       rd_from_memory, out_from_memory,
                       write_reg_from_memory, select_from_memory,
                       misaligned_from_memory,
                       bus_error_from_memory} !== '0) begin
                     errs++;
                     $display("FAIL rnd%0d_bubble%0d: wr=%b res=%h",
                              n, c, write_reg_from_memory,
                              result_from_memory);
                  end
               end
               dmem_ready = (c == lat);
               dmem_rdata = $urandom;
               if (c == lat) rdat = dmem_rdata;
               #1;
               vecs++;
               if ({dmem_req, dmem_we, dmem_addr, dmem_be} !==
                   {1'b1, mw, ea, m_be(f3, a)}) begin
                  errs++;
                  $display("FAIL rnd%0d_bus%0d: req=%b we=%b a=%h be=%b want a=%h be=%b",
                           n, c, dmem_req, dmem_we, dmem_addr, dmem_be,
                           ea, m_be(f3, a));
               end
               if (mw) begin
                  vecs++;
                  if (dmem_wdata !== m_wdata(f3, sd)) begin
                     errs++;
                     $display("FAIL rnd%0d_wdata: got %h want %h", n,
                              dmem_wdata, m_wdata(f3, sd));
                  end
               end
               vecs++;
               if (stall_from_memory !== (c != lat)) begin
                  errs++;
                  $display("FAIL rnd%0d_stall%0d: got %b want %b", n,
                           c, stall_from_memory, c != lat);
               end
               if (c == lat) done = 1'b1;
            end
            @(negedge clk);
            idle_in();
            dmem_ready = 1'b0;
            vecs++;
            if (done) begin
               if ({result_from_memory, funct3_from_memory,
                    rd_from_memory, out_from_memory,
                    write_reg_from_memory, select_from_memory,
                    bus_error_from_memory} !==
                   {a, f3, rd, (mw ? 32'h0 : rdat), wr & ~mw, sel,
                    1'b0}) begin
                  errs++;
                  $display("FAIL rnd%0d_done: res=%h out=%h wr=%b want res=%h out=%h wr=%b",
                           n, result_from_memory, out_from_memory,
                           write_reg_from_memory, a,
                           (mw ? 32'h0 : rdat), wr & ~mw);
               end
            end else if ({bus_error_from_memory,
                          write_reg_from_memory,
                          out_from_memory} !== {1'b1, 1'b0, 32'h0}) begin
               errs++;
               $display("FAIL rnd%0d_timeout: berr=%b wr=%b out=%h", n,
                        bus_error_from_memory, write_reg_from_memory,
                        out_from_memory);
            end
         end
      end
   endtask

   initial begin
      idle_in();
      rst        = 1'b1;
      dmem_ready = 1'b0;
      dmem_rdata = 32'h0;
      test_reset();
      test_alu();
      test_store_same_cycle();
      test_load_wait();
      test_misaligned();
      test_timeout();
      test_reset_in_wait();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
